// File: rtl/cve2_wb_stage.sv
// cve2_wb_stage: in-order writeback/retire buffer between EX/LSU and the
// register file. ALU/MUL/DIV/MAC results are complete on entry; loads wait
// for the LSU response and are byte/half extracted before retiring. The RF
// write port is fully registered.
// Optional: define CVE2_WB_FWD_EN to add a combinational operand-forwarding
// lookup over the buffer and the registered write-port entry.
module cve2_wb_stage #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [DataWidth-1:0] ex_result_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic                 ex_rd_we_i,
  input  logic                 ex_is_load_i,
  input  logic [1:0]           ex_load_type_i,
  input  logic                 ex_load_sign_i,
  input  logic [1:0]           ex_addr_lsb_i,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
`ifdef CVE2_WB_FWD_EN
  input  logic [4:0]           id_raddr_i,
  output logic                 fwd_hit_o,
  output logic [DataWidth-1:0] fwd_data_o,
  output logic                 fwd_stall_o,
`endif
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 load_pending_o,
  output logic                 load_err_o,
  output logic                 instr_retired_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [4:0]           rd;
    logic                 we;
    logic                 done;   // data is final (non-load, or load response seen)
    logic                 err;
    logic [1:0]           ltype;
    logic                 lsign;
    logic [1:0]           lsb;
  } entry_t;

  entry_t entries_q [Depth];
  ptr_t   rd_ptr_q, wr_ptr_q, pend_idx_q;
  cnt_t   count_q;
  logic   pend_q;

  // Byte/half extraction of an already word-aligned LSU response.
  function automatic logic [DataWidth-1:0] extract(input logic [DataWidth-1:0] rdata,
                                                   input logic [1:0] ltype,
                                                   input logic       sign,
                                                   input logic [1:0] lsb);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lsb, 3'b000} +: 8];
    h = rdata[{lsb[1], 4'b0000} +: 16];
    case (ltype)
      2'b01:   extract = {{16{sign & h[15]}}, h};
      2'b10:   extract = {{24{sign & b[7]}}, b};
      default: extract = rdata;
    endcase
  endfunction

  logic                 full, push, bypass, store, rsp, head_rsp, pop_buf, retire;
  logic [DataWidth-1:0] rsp_data;
  entry_t               head, pend;
  logic                 ret_we, ret_err;
  logic [4:0]           ret_rd;
  logic [DataWidth-1:0] ret_data;

  assign full       = (count_q == cnt_t'(Depth));
  // Only one incomplete load may be outstanding; ready looks at registered occupancy.
  assign ex_ready_o = !full && !(pend_q && ex_is_load_i);
  assign push       = ex_valid_i && ex_ready_o;
  // A complete result into an empty buffer goes straight to the write-port register.
  assign bypass     = push && (count_q == '0) && !ex_is_load_i;
  assign store      = push && !bypass;
  // A response with nothing pending, or a push-cycle load, is not ours.
  assign rsp        = lsu_rvalid_i && pend_q;
  assign head       = entries_q[rd_ptr_q];
  assign pend       = entries_q[pend_idx_q];
  assign rsp_data   = extract(lsu_rdata_i, pend.ltype, pend.lsign, pend.lsb);
  assign head_rsp   = rsp && (pend_idx_q == rd_ptr_q);
  assign pop_buf    = (count_q != '0) && (head.done || head_rsp);
  assign retire     = pop_buf || bypass;
  assign load_pending_o = pend_q;

  // Select the entry retiring this cycle: buffer head, or the bypassed EX result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ret_we   = 1'b0;
    ret_rd   = '0;
    ret_data = '0;
    ret_err  = 1'b0;
    if (pop_buf) begin
      ret_we   = head.we;
      ret_rd   = head.rd;
      ret_data = head_rsp ? rsp_data  : head.data;
      ret_err  = head_rsp ? lsu_err_i : head.err;
    end else if (bypass) begin
      ret_we   = ex_rd_we_i;
      ret_rd   = ex_rd_addr_i;
      ret_data = ex_result_i;
    end
  end

  // Pointer, occupancy and pending-load bookkeeping.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      if (store)   wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop_buf) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({store, pop_buf})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      if (store && ex_is_load_i) begin
        pend_q     <= 1'b1;
        pend_idx_q <= wr_ptr_q;
      end else if (rsp) begin
        pend_q     <= 1'b0;
      end
    end
  end

  // Entry storage: fill on push, complete the pending load on its response.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; occupancy and pointers alone decide which entries are live.
    if (store) begin
      entries_q[wr_ptr_q] <= '{data:  ex_result_i,
                               rd:    ex_rd_addr_i,
                               we:    ex_rd_we_i,
                               done:  !ex_is_load_i,
                               err:   1'b0,
                               ltype: ex_load_type_i,
                               lsign: ex_load_sign_i,
                               lsb:   ex_addr_lsb_i};
    end
    if (rsp) begin
      entries_q[pend_idx_q].data <= rsp_data;
      entries_q[pend_idx_q].err  <= lsu_err_i;
      entries_q[pend_idx_q].done <= 1'b1;
    end
  end

  // Registered RF write port and retire pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o         <= 1'b0;
      rf_waddr_o      <= '0;
      rf_wdata_o      <= '0;
      load_err_o      <= 1'b0;
      instr_retired_o <= 1'b0;
    end else begin
      rf_we_o         <= retire && ret_we && (ret_rd != 5'd0) && !ret_err;
      rf_waddr_o      <= (retire && ret_we && (ret_rd != 5'd0) && !ret_err) ? ret_rd : 5'd0;
      rf_wdata_o      <= (retire && ret_we && (ret_rd != 5'd0) && !ret_err) ? ret_data : '0;
      load_err_o      <= retire && ret_err;
      instr_retired_o <= retire;
    end
  end

`ifdef CVE2_WB_FWD_EN
  // Forwarding lookup: oldest (write port) first, later buffer entries override.
  always_comb begin
    ptr_t idx;
    fwd_hit_o   = 1'b0;
    fwd_stall_o = 1'b0;
    fwd_data_o  = '0;
    idx         = '0;
    if (id_raddr_i != 5'd0) begin
      if (rf_we_o && (rf_waddr_o == id_raddr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = rf_wdata_o;
      end
      for (int i = 0; i < int'(Depth); i++) begin
        idx = rd_ptr_q + ptr_t'(i);
        if ((cnt_t'(i) < count_q) && entries_q[idx].we && (entries_q[idx].rd == id_raddr_i)) begin
          fwd_hit_o   = entries_q[idx].done;
          fwd_stall_o = !entries_q[idx].done;
          fwd_data_o  = entries_q[idx].done ? entries_q[idx].data : '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cve2_wb_stage.sv
// tb_cve2_wb_stage: directed-vector bench for cve2_wb_stage. Stimulus pushes
// expected retire records into a scoreboard queue; a negedge monitor pops and
// compares on every instr_retired_o pulse. Define CVE2_WB_FWD_EN to include
// the forwarding checks.
module tb_cve2_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_result_i = '0;
  logic [4:0]  ex_rd_addr_i = '0;
  logic        ex_rd_we_i = 1'b0;
  logic        ex_is_load_i = 1'b0;
  logic [1:0]  ex_load_type_i = '0;
  logic        ex_load_sign_i = 1'b0;
  logic [1:0]  ex_addr_lsb_i = '0;
  logic        lsu_rvalid_i = 1'b0;
  logic [31:0] lsu_rdata_i = '0;
  logic        lsu_err_i = 1'b0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        load_pending_o;
  logic        load_err_o;
  logic        instr_retired_o;
`ifdef CVE2_WB_FWD_EN
  logic [4:0]  id_raddr_i = '0;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic        fwd_stall_o;
`endif

  cve2_wb_stage #(.Depth(2), .DataWidth(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .ex_result_i     (ex_result_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_rd_we_i      (ex_rd_we_i),
    .ex_is_load_i    (ex_is_load_i),
    .ex_load_type_i  (ex_load_type_i),
    .ex_load_sign_i  (ex_load_sign_i),
    .ex_addr_lsb_i   (ex_addr_lsb_i),
    .lsu_rvalid_i    (lsu_rvalid_i),
    .lsu_rdata_i     (lsu_rdata_i),
    .lsu_err_i       (lsu_err_i),
`ifdef CVE2_WB_FWD_EN
    .id_raddr_i      (id_raddr_i),
    .fwd_hit_o       (fwd_hit_o),
    .fwd_data_o      (fwd_data_o),
    .fwd_stall_o     (fwd_stall_o),
`endif
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .load_pending_o  (load_pending_o),
    .load_err_o      (load_err_o),
    .instr_retired_o (instr_retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one EX result; optionally record what its retire must look like.
  task automatic push(input logic [4:0] rd, input logic we, input logic ld,
                      input logic [1:0] lt, input logic sg, input logic [1:0] lsb,
                      input logic [31:0] res, input logic [31:0] exp_data,
                      input logic exp_err, input bit track);
    logic w;
    ex_valid_i     = 1'b1;
    ex_rd_addr_i   = rd;
    ex_rd_we_i     = we;
    ex_is_load_i   = ld;
    ex_load_type_i = lt;
    ex_load_sign_i = sg;
    ex_addr_lsb_i  = lsb;
    ex_result_i    = res;
    #1;
    check("ready on push", 64'(ex_ready_o), 64'd1);
    if (track) begin
      w = we && (rd != 5'd0) && !exp_err;
      sb.push_back('{we: w, addr: w ? rd : 5'd0, data: w ? exp_data : 32'd0, err: exp_err});
    end
    step();
    ex_valid_i   = 1'b0;
    ex_is_load_i = 1'b0;
    ex_rd_we_i   = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res, input bit track);
    push(rd, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, res, res, 1'b0, track);
  endtask

  task automatic ld(input logic [4:0] rd, input logic [1:0] lt, input logic sg,
                    input logic [1:0] lsb, input logic [31:0] exp_data,
                    input logic exp_err, input bit track);
    push(rd, 1'b1, 1'b1, lt, sg, lsb, 32'h0, exp_data, exp_err, track);
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    lsu_rvalid_i = 1'b1;
    lsu_rdata_i  = data;
    lsu_err_i    = err;
    step();
    lsu_rvalid_i = 1'b0;
    lsu_err_i    = 1'b0;
  endtask

  // Monitor: every retire pulse must match the oldest expectation; otherwise outputs stay quiet.
  always @(negedge clk_i) begin
    exp_t e;
    if (started && !rst_i) begin
      if (instr_retired_o) begin
        if (sb.size() == 0) begin
          check("unexpected retire", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("retire record", 64'({rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o}), 64'(e));
        end
      end else begin
        check("idle outputs", 64'({rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset rf_we", 64'(rf_we_o), 64'd0);
    check("reset retired", 64'(instr_retired_o), 64'd0);
    check("reset pending", 64'(load_pending_o), 64'd0);
    check("reset ready", 64'(ex_ready_o), 64'd1);
    started = 1'b1;

    // ALU result writes the cycle after the push
    alu(5'd5, 32'hDEADBEEF, 1'b1);
    check("alu latency we", 64'(rf_we_o), 64'd1);
    check("alu latency addr", 64'(rf_waddr_o), 64'd5);
    check("alu latency data", 64'(rf_wdata_o), 64'hDEADBEEF);
    check("alu retired pulse", 64'(instr_retired_o), 64'd1);
    step();

    // Load extraction variants
    ld(5'd1, 2'b10, 1'b1, 2'd2, 32'hFFFFFFF0, 1'b0, 1'b1);
    check("load pending", 64'(load_pending_o), 64'd1);
    respond(32'h12F03456, 1'b0);
    check("load latency we", 64'(rf_we_o), 64'd1);
    check("signed byte data", 64'(rf_wdata_o), 64'hFFFFFFF0);
    ld(5'd2, 2'b01, 1'b0, 2'd2, 32'h000012F0, 1'b0, 1'b1);
    respond(32'h12F03456, 1'b0);
    ld(5'd12, 2'b01, 1'b1, 2'd3, 32'hFFFF8000, 1'b0, 1'b1);
    respond(32'h80001234, 1'b0);
    ld(5'd13, 2'b10, 1'b0, 2'd1, 32'h00000034, 1'b0, 1'b1);
    respond(32'h12F03456, 1'b0);
    ld(5'd14, 2'b11, 1'b1, 2'd3, 32'hA5A50F0F, 1'b0, 1'b1);
    respond(32'hA5A50F0F, 1'b0);
    step();

    // ALU behind a pending load stalls; retire order preserved
    ld(5'd3, 2'b00, 1'b0, 2'd0, 32'hCAFE0001, 1'b0, 1'b1);
    ex_is_load_i = 1'b1;
    #1;
    check("ready blocked by pending load", 64'(ex_ready_o), 64'd0);
    ex_is_load_i = 1'b0;
    #1;
    check("ready for alu behind load", 64'(ex_ready_o), 64'd1);
    alu(5'd4, 32'h11, 1'b1);
    check("ready when full", 64'(ex_ready_o), 64'd0);
    step();
    step();
    check("no write while head pending", 64'(rf_we_o), 64'd0);
    respond(32'hCAFE0001, 1'b0);
    check("head load first", 64'({rf_we_o, rf_waddr_o}), 64'({1'b1, 5'd3}));
    step();
    check("alu next cycle", 64'({rf_we_o, rf_waddr_o, rf_wdata_o}), 64'({1'b1, 5'd4, 32'h11}));
    step();

    // Errored load: no write, error pulse, then ALU entry writes
    ld(5'd6, 2'b00, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    alu(5'd8, 32'h22, 1'b1);
    check("ready full with pending head", 64'(ex_ready_o), 64'd0);
    respond(32'hDEAD0000, 1'b1);
    check("load_err pulse", 64'(load_err_o), 64'd1);
    check("errored load no write", 64'({rf_we_o, rf_wdata_o}), 64'd0);
    step();
    check("alu after error", 64'({rf_we_o, rf_waddr_o, load_err_o}), 64'({1'b1, 5'd8, 1'b0}));
    step();

    // rd=0 retires without writing; spurious response is ignored
    alu(5'd0, 32'h55, 1'b1);
    check("rd0 retired pulse", 64'(instr_retired_o), 64'd1);
    check("rd0 no write", 64'(rf_we_o), 64'd0);
    step();
    respond(32'h77777777, 1'b1);
    check("spurious rvalid quiet", 64'({instr_retired_o, rf_we_o, load_err_o, load_pending_o}), 64'd0);
    step();

`ifdef CVE2_WB_FWD_EN
    // Forwarding
    id_raddr_i = 5'd0;
    ld(5'd7, 2'b00, 1'b0, 2'd0, 32'h1, 1'b0, 1'b1);
    check("fwd raddr0 quiet", 64'({fwd_hit_o, fwd_stall_o, fwd_data_o}), 64'd0);
    id_raddr_i = 5'd7;
    #1;
    check("fwd stall on pending load", 64'({fwd_hit_o, fwd_stall_o}), 64'({1'b0, 1'b1}));
    alu(5'd7, 32'h2, 1'b1);
    check("fwd younger alu over load", 64'({fwd_hit_o, fwd_stall_o, fwd_data_o}), 64'({1'b1, 1'b0, 32'h2}));
    respond(32'h1, 1'b0);
    check("fwd youngest of two", 64'({fwd_hit_o, fwd_stall_o, fwd_data_o}), 64'({1'b1, 1'b0, 32'h2}));
    step();
    check("fwd from write port", 64'({fwd_hit_o, fwd_data_o}), 64'({1'b1, 32'h2}));
    step();
    check("fwd no match", 64'({fwd_hit_o, fwd_stall_o, fwd_data_o}), 64'd0);
    id_raddr_i = 5'd0;
`endif

    // Reset with two entries and a pending load; response in reset cycle and later ignored
    ld(5'd9, 2'b00, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    alu(5'd10, 32'h33, 1'b0);
    check("pending before reset", 64'(load_pending_o), 64'd1);
    rst_i        = 1'b1;
    lsu_rvalid_i = 1'b1;
    lsu_rdata_i  = 32'h99999999;
    step();
    rst_i        = 1'b0;
    lsu_rvalid_i = 1'b0;
    check("post-reset outputs", 64'({rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o, instr_retired_o, load_pending_o}), 64'd0);
    check("post-reset ready", 64'(ex_ready_o), 64'd1);
    respond(32'hABCD0000, 1'b0);
    check("late rvalid ignored", 64'({instr_retired_o, rf_we_o, load_pending_o}), 64'd0);
    step();
    check("late rvalid no retire", 64'(instr_retired_o), 64'd0);

    repeat (3) step();
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cve2_wb_stage.md
Name: cve2_wb_stage

Overview:
- Writeback stage directly downstream of the EX block: consumes EX results (result_ex_o/ex_valid_o) and LSU load responses.
- Retires them in program order into the register-file write port.
- In-order retire buffer of Depth entries. ALU/MUL/DIV/MAC results arrive complete. Load entries wait for the LSU response, then are byte/half extracted.
- Registered write port only; no combinational path from EX result to the RF.

Parameters:
- Depth, 2, retire buffer entries (power of two, >=2)
- DataWidth, 32, result/write data width (only 32 supported)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX result valid (from ex_valid_o)
- ex_ready_o  out  1  stage can accept this cycle
- ex_result_i  in  32  EX result (result_ex_o); ignored for loads
- ex_rd_addr_i  in  5  destination register
- ex_rd_we_i  in  1  instruction writes rd
- ex_is_load_i  in  1  entry is a load; data comes from LSU
- ex_load_type_i  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- ex_load_sign_i  in  1  sign-extend sub-word load
- ex_addr_lsb_i  in  2  load address bits [1:0]
- lsu_rvalid_i  in  1  load response valid
- lsu_rdata_i  in  32  raw aligned load word
- lsu_err_i  in  1  load bus error, qualified by lsu_rvalid_i
- rf_we_o  out  1  RF write enable
- rf_waddr_o  out  5  RF write address
- rf_wdata_o  out  32  RF write data
- load_pending_o  out  1  buffer holds an incomplete load
- load_err_o  out  1  one-cycle pulse: load retired with error
- instr_retired_o  out  1  one-cycle pulse per retired entry

Behaviour:
- Reset (rst_i=1 at posedge):
  - buffer emptied; pending load dropped
  - all outputs 0 from the next cycle
  - ex_ready_o=1 once reset deasserts
- Reset mid-operation discards all entries with no RF write. An lsu_rvalid_i in the same cycle as reset is ignored.
- Accept on ex_valid_i && ex_ready_o.
- ex_ready_o = !full && !(load_pending && ex_is_load_i): at most one incomplete load. The combinational dependency on ex_is_load_i is allowed; upstream holds inputs stable while valid.
- Entry state:
  - non-load: complete on push, data = ex_result_i
  - load: incomplete until lsu_rvalid_i; data = extracted lsu_rdata_i
- lsu_rvalid_i completes the single pending load, wherever it is in the buffer. lsu_rvalid_i with no pending load is ignored.
- Push of a load and lsu_rvalid_i in the same cycle: the response belongs to the older pending load. The new load becomes pending the next cycle.
- Load extraction:
  - byte: lsu_rdata_i[8*lsb+:8]
  - half: lsu_rdata_i[16*lsb[1]+:16]; lsb[0] ignored because the LSU has already realigned
  - sign- or zero-extend per ex_load_sign_i
  - word: unchanged
- Retire: each cycle, if the head is complete, it pops.
  - rf_we_o/rf_waddr_o/rf_wdata_o are registered and valid the cycle after the pop
  - rf_we_o = rd_we && rd!=0 && !err
  - instr_retired_o pulses for every pop, including rd=0 and error entries
  - load_err_o pulses together with the errored load's retire
- An errored load writes nothing: rf_we_o=0, rf_wdata_o=0.
- Latency:
  - non-load accepted at cycle N into an empty buffer → rf_we_o at N+1
  - load response at cycle M with the load at head → rf_we_o at M+1
  - a complete entry behind an incomplete head stalls until the head completes; max one retire per cycle
- Full buffer: ex_ready_o=0. A pop that cycle does not raise ready in the same cycle; ready is based on registered occupancy.
- Simultaneous push and pop: both occur; occupancy unchanged.
- Pointers wrap modulo Depth.
- rf_waddr_o and rf_wdata_o are 0 whenever rf_we_o=0.

Optional Feature:
- Macro: CVE2_WB_FWD_EN.
- Defined: adds ports id_raddr_i (in, 5), fwd_hit_o (out, 1), fwd_data_o (out, 32), fwd_stall_o (out, 1). Lookup is combinational over the buffer plus the registered write-port entry.
  - The youngest entry with rd_we && rd==id_raddr_i && rd!=0 is selected.
  - If that entry is complete: fwd_hit_o=1, fwd_data_o=its data.
  - If it is an incomplete load: fwd_stall_o=1, fwd_hit_o=0.
  - No match, or id_raddr_i=0: all three outputs 0.
- Undefined: these ports and the lookup logic do not exist; all other behaviour is identical.

Test Plan:
- ALU push: ex_result_i=0xDEADBEEF, rd=5 at cycle 1 → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF at cycle 2; instr_retired_o pulse.
- Signed byte load, lsb=2, then lsu_rdata_i=0x12F03456 → rf_wdata_o=0xFFFFFFF0. Unsigned half, lsb=2, same data → 0x000012F0.
- Load to rd=3, then ALU to rd=4 (0x11); response arrives 3 cycles later → rd=3 written first, rd=4 the next cycle; ready=0 for a second load while the first is pending.
- Depth=2 filled with a pending load at head → ex_ready_o=0. lsu_err_i=1 with rvalid → load_err_o pulse, rf_we_o=0, then the ALU entry writes.
- rd=0 ALU push → no RF write, instr_retired_o pulse. Spurious lsu_rvalid_i with an empty buffer → no output activity.
- rst_i asserted with 2 entries and a pending load → next cycle all outputs 0, ready=1; a late lsu_rvalid_i after reset is ignored.
- (CVE2_WB_FWD_EN) Buffer holds rd=7 entries 0x1 (older) and 0x2 (younger), id_raddr_i=7 → fwd_hit_o=1, fwd_data_o=0x2. Incomplete load to rd=7 as the youngest match → fwd_stall_o=1, fwd_hit_o=0.
